// File: rtl/fine_time_readout_arb.sv
// Four-channel fine-time hit capture: one-deep time-stamped holding per channel,
// round-robin readout onto a single valid/ready stream, and local-bus registers.
module fine_time_readout_arb #(
  parameter logic [7:0] BASE = 8'hE8,
  parameter int         TSW  = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [127:0]    hit_in,
  input  logic [11:0]     pid_in,
  output logic [36+TSW:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic [31:0]     DataIn,
  input  logic [7:0]      Address,
  input  logic            Read,
  input  logic            Write,
  output logic [31:0]     DataOut
);

  localparam int         EW        = 35 + TSW;
  localparam logic [7:0] ADDR_CTRL = BASE;
  localparam logic [7:0] ADDR_D01  = BASE + 8'd1;
  localparam logic [7:0] ADDR_D23  = BASE + 8'd2;

  logic [TSW-1:0]  ts_q;
  logic [EW-1:0]   h_q    [4];
  logic [EW-1:0]   h_d    [4];
  logic [15:0]     drop_q [4];
  logic [15:0]     drop_d [4];
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      en_q, en_d;
  logic            out_valid_q, out_valid_d;
  logic [36+TSW:0] out_data_q, out_data_d;
  logic [1:0]      last_q, last_d;

  logic       slot_free, gnt_any, wr_ctrl, clr;
  logic [1:0] gnt_idx, cand;
  logic [3:0] granted, cap;
  logic       unused_datain;

  assign unused_datain = ^{DataIn[31:9], DataIn[7:4]};
  assign wr_ctrl       = Write && (Address == ADDR_CTRL);
  assign clr           = wr_ctrl && DataIn[8];

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    gnt_any   = 1'b0;
    gnt_idx   = last_q;
    cand      = last_q;
    // Walk farthest to nearest so the channel just after last wins.
    for (int i = 4; i >= 1; i--) begin
      cand = last_q + 2'(i);
      if (pend_q[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    granted = '0;
    if (slot_free && gnt_any) granted[gnt_idx] = 1'b1;
  end

  always_comb begin
    en_d = wr_ctrl ? DataIn[3:0] : en_q;
    cap  = '0;
    for (int n = 0; n < 4; n++) begin
      cap[n]    = (|hit_in[32*n +: 32]) && en_q[n];
      pend_d[n] = pend_q[n] && !granted[n];
      h_d[n]    = h_q[n];
      drop_d[n] = drop_q[n];
      if (cap[n] && !pend_d[n]) begin
        h_d[n]    = {pid_in[3*n +: 3], ts_q, hit_in[32*n +: 32]};
        pend_d[n] = 1'b1;
      end else if (cap[n] && drop_q[n] != 16'hFFFF) begin
        drop_d[n] = drop_q[n] + 16'd1;
      end
      if (clr) drop_d[n] = '0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    if (slot_free) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = {gnt_idx, h_q[gnt_idx]};
        last_d     = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q        <= '0;
      pend_q      <= '0;
      en_q        <= 4'hF;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_q      <= 2'd3;
      for (int n = 0; n < 4; n++) begin
        h_q[n]    <= '0;
        drop_q[n] <= '0;
      end
    end else begin
      ts_q        <= ts_q + TSW'(1);
      pend_q      <= pend_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_q      <= last_d;
      for (int n = 0; n < 4; n++) begin
        h_q[n]    <= h_d[n];
        drop_q[n] <= drop_d[n];
      end
    end
  end

  always_comb begin
    DataOut = '0;
    if (Read) begin
      if (Address == ADDR_CTRL)     DataOut = {28'd0, en_q};
      else if (Address == ADDR_D01) DataOut = {drop_q[1], drop_q[0]};
      else if (Address == ADDR_D23) DataOut = {drop_q[3], drop_q[2]};
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fine_time_readout_arb.sv
// Bench for fine_time_readout_arb: directed scenarios plus randomized traffic
// compared each cycle against an entry-level behavioural model.
module tb_fine_time_readout_arb;
  localparam int         TSW  = 11;
  localparam int         OW   = 37 + TSW;
  localparam logic [7:0] BASE = 8'hE8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [127:0]   hit_in = '0;
  logic [11:0]    pid_in = '0;
  logic [OW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [31:0]    DataIn = '0;
  logic [7:0]     Address = '0;
  logic           Read = 1'b0;
  logic           Write = 1'b0;
  logic [31:0]    DataOut;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  fine_time_readout_arb #(.BASE(BASE), .TSW(TSW)) dut (
    .clk(clk), .rst(rst), .hit_in(hit_in), .pid_in(pid_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .DataIn(DataIn), .Address(Address), .Read(Read), .Write(Write),
    .DataOut(DataOut)
  );

  // Reference model: per-channel one-entry slot, pointer-based round robin.
  int            m_ts, m_last, m_g;
  logic [34+TSW:0] m_h [4];
  bit            m_pend [4];
  int            m_drop [4];
  logic [3:0]    m_en;
  bit            m_ov, m_free;
  logic [OW-1:0] m_od;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ts = 0; m_last = 3; m_en = 4'hF; m_ov = 0; m_od = '0;
      for (int n = 0; n < 4; n++) begin
        m_h[n] = '0; m_pend[n] = 0; m_drop[n] = 0;
      end
    end else begin
      m_free = !m_ov || out_ready;
      m_g = -1;
      if (m_free)
        for (int k = 1; k <= 4; k++)
          if (m_g < 0 && m_pend[(m_last + k) % 4]) m_g = (m_last + k) % 4;
      if (m_free) begin
        if (m_g >= 0) begin
          m_ov = 1; m_od = {2'(m_g), m_h[m_g]}; m_pend[m_g] = 0; m_last = m_g;
        end else m_ov = 0;
      end
      for (int n = 0; n < 4; n++) begin
        if (hit_in[32*n +: 32] != 0 && m_en[n]) begin
          if (m_pend[n]) begin
            if (m_drop[n] < 65535) m_drop[n]++;
          end else begin
            m_h[n] = {pid_in[3*n +: 3], TSW'(m_ts), hit_in[32*n +: 32]};
            m_pend[n] = 1;
          end
        end
      end
      if (Write && Address == BASE) begin
        if (DataIn[8]) for (int n = 0; n < 4; n++) m_drop[n] = 0;
        m_en = DataIn[3:0];
      end
      m_ts = (m_ts + 1) % (1 << TSW);
    end
  end

  function automatic logic [31:0] m_read(input logic [7:0] a, input logic rd);
    if (!rd) return 32'h0;
    if (a == BASE)      return {28'd0, m_en};
    if (a == BASE + 1)  return {m_drop[1][15:0], m_drop[0][15:0]};
    if (a == BASE + 2)  return {m_drop[3][15:0], m_drop[2][15:0]};
    return 32'h0;
  endfunction

  function automatic logic [31:0] rnd_pat();
    logic [31:0] p;
    p = $urandom();
    if (p == 0) p = 32'h1;
    return p;
  endfunction

  task automatic idle();
    hit_in = '0; pid_in = '0; Write = 0; Read = 0; DataIn = '0; Address = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; idle(); out_ready = 1;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; idle(); out_ready = 1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vectors++;
    if (out_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", out_data); end
    vectors++;
    if (DataOut !== 32'h0) begin miscompares++; $display("FAIL reset_dataout_noread: got %h expected 0", DataOut); end
    Read = 1; Address = BASE; #1;
    vectors++;
    if (DataOut !== 32'hF) begin miscompares++; $display("FAIL reset_ctrl: got %h expected f", DataOut); end
    Address = BASE + 8'd1; #1;
    vectors++;
    if (DataOut !== 32'h0) begin miscompares++; $display("FAIL reset_drop01: got %h expected 0", DataOut); end
    @(negedge clk);
    idle(); rst = 1;
  endtask

  task automatic test_single_hit();
    do_reset();
    repeat (5) step();
    hit_in = 128'h0000_0F00 << 64; pid_in = 12'b001 << 6;
    step();
    idle();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early: got %b expected 0", out_valid); end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== {2'd2, 3'b001, 11'd5, 32'h0000_0F00}) begin
      miscompares++; $display("FAIL single_entry: got v=%b %h expected v=1 %h", out_valid, out_data, {2'd2, 3'b001, 11'd5, 32'h0000_0F00});
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_len: got %b expected 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] pats [4];
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int n = 0; n < 4; n++) begin
        pats[n] = rnd_pat();
        hit_in[32*n +: 32] = pats[n];
      end
      pid_in = 12'($urandom());
      step();
      idle();
      for (int k = 0; k < 4; k++) begin
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_data[OW-1 -: 2] !== 2'(k) || out_data[31:0] !== pats[k]) begin
          miscompares++; $display("FAIL rr_order: got v=%b ch=%0d pat=%h expected ch=%0d pat=%h", out_valid, out_data[OW-1 -: 2], out_data[31:0], k, pats[k]);
        end
        vectors++;
        if (out_data !== m_od) begin miscompares++; $display("FAIL rr_model: got %h expected %h", out_data, m_od); end
      end
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rr_end: got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pats [3];
    int cnt;
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      pats[i] = rnd_pat();
      hit_in = {96'd0, pats[i]};
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data[31:0] !== pats[0]) begin
        miscompares++; $display("FAIL bp_hold: got v=%b pat=%h expected v=1 pat=%h", out_valid, out_data[31:0], pats[0]);
      end
      step();
    end
    Read = 1; Address = BASE + 8'd1; #1;
    vectors++;
    if (DataOut !== 32'h0000_0001) begin miscompares++; $display("FAIL bp_drop: got %h expected 00000001", DataOut); end
    Read = 0;
    out_ready = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        vectors++;
        if (cnt > 1 || out_data[31:0] !== pats[cnt]) begin
          miscompares++; $display("FAIL bp_drain_entry: got pat=%h index=%0d expected pat=%h", out_data[31:0], cnt, pats[cnt > 1 ? 1 : cnt]);
        end
        cnt++;
      end
      step();
    end
    vectors++;
    if (cnt !== 2) begin miscompares++; $display("FAIL bp_count: got %0d expected 2", cnt); end
  endtask

  task automatic test_same_edge();
    int cnt;
    do_reset();
    out_ready = 1;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) hit_in = {64'd0, rnd_pat(), 32'd0};
      else idle();
      step();
      vectors++;
      if (out_valid !== m_ov || (m_ov && out_data !== m_od)) begin
        miscompares++; $display("FAIL reload_stream: got v=%b %h expected v=%b %h", out_valid, out_data, m_ov, m_od);
      end
      if (out_valid) cnt++;
    end
    vectors++;
    if (cnt !== 10) begin miscompares++; $display("FAIL reload_count: got %0d expected 10", cnt); end
    Read = 1; Address = BASE + 8'd1; #1;
    vectors++;
    if (DataOut !== 32'h0) begin miscompares++; $display("FAIL reload_drop: got %h expected 0", DataOut); end
    Read = 0;
  endtask

  task automatic test_registers();
    int cnt;
    bit [3:0] seen;
    do_reset();
    Write = 1; Address = BASE; DataIn = 32'h0000_0005;
    step();
    idle();
    Read = 1; Address = BASE; #1;
    vectors++;
    if (DataOut !== 32'h5) begin miscompares++; $display("FAIL reg_ctrl5: got %h expected 5", DataOut); end
    idle();
    for (int n = 0; n < 4; n++) hit_in[32*n +: 32] = rnd_pat();
    step();
    idle();
    cnt = 0; seen = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) begin cnt++; seen[out_data[OW-1 -: 2]] = 1'b1; end
    end
    vectors++;
    if (cnt !== 2 || seen !== 4'b0101) begin
      miscompares++; $display("FAIL reg_enable: got count=%0d chans=%b expected count=2 chans=0101", cnt, seen);
    end
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      hit_in = {96'd0, rnd_pat()};
      hit_in[64 +: 32] = rnd_pat();
      step();
    end
    idle();
    Read = 1; Address = BASE + 8'd1; #1;
    vectors++;
    if (DataOut !== m_read(Address, Read) || DataOut === 32'h0) begin
      miscompares++; $display("FAIL reg_drops_before_clr: got %h expected %h", DataOut, m_read(Address, Read));
    end
    idle();
    Write = 1; Address = BASE; DataIn = 32'h0000_0105;
    step();
    idle();
    Read = 1;
    for (int a = 0; a < 5; a++) begin
      logic [7:0] addr;
      logic [31:0] want;
      addr = (a == 4) ? 8'h00 : BASE + 8'(a);
      want = (a == 0) ? 32'h5 : 32'h0;
      Address = addr; #1;
      vectors++;
      if (DataOut !== want) begin miscompares++; $display("FAIL reg_read_%02h: got %h expected %h", addr, DataOut, want); end
    end
    Read = 0; Address = BASE; #1;
    vectors++;
    if (DataOut !== 32'h0) begin miscompares++; $display("FAIL reg_noread: got %h expected 0", DataOut); end
    Write = 1; Address = BASE + 8'd1; DataIn = 32'hFFFF_FFFF;
    step();
    idle();
    Read = 1; Address = BASE + 8'd1; #1;
    vectors++;
    if (DataOut !== 32'h0) begin miscompares++; $display("FAIL reg_ro_write: got %h expected 0", DataOut); end
    idle();
    out_ready = 1;
    repeat (4) step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 4; n++)
        hit_in[32*n +: 32] = ($urandom_range(0, 9) < 4) ? rnd_pat() : 32'd0;
      pid_in    = 12'($urandom());
      out_ready = ($urandom_range(0, 9) < 7);
      Write = 0; DataIn = '0;
      if ($urandom_range(0, 19) == 0) begin
        Write   = 1;
        Address = BASE + 8'($urandom_range(0, 2));
        DataIn  = {23'd0, 1'($urandom_range(0, 3) == 0), 4'd0, ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF};
      end else begin
        Address = ($urandom_range(0, 4) == 4) ? 8'h00 : BASE + 8'($urandom_range(0, 3));
      end
      Read = 1'($urandom());
      step();
      vectors++;
      if (out_valid !== m_ov || (m_ov && out_data !== m_od)) begin
        miscompares++; $display("FAIL rand_stream@%0d: got v=%b %h expected v=%b %h", i, out_valid, out_data, m_ov, m_od);
      end
      vectors++;
      if (DataOut !== m_read(Address, Read)) begin
        miscompares++; $display("FAIL rand_read@%0d: got %h expected %h", i, DataOut, m_read(Address, Read));
      end
    end
    idle();
    out_ready = 1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] pat;
    do_reset();
    out_ready = 0;
    for (int n = 0; n < 3; n++) hit_in[32*n +: 32] = rnd_pat();
    step();
    idle();
    step();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got %b expected 1", out_valid); end
    #2 rst = 0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      miscompares++; $display("FAIL mid_async: got v=%b %h expected v=0 0", out_valid, out_data);
    end
    @(negedge clk);
    rst = 1; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_ghost@%0d: got %b expected 0", i, out_valid); end
    end
    pat = rnd_pat();
    hit_in = {pat, 96'd0}; pid_in = 12'b100 << 9;
    step();
    idle();
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== {2'd3, 3'b100, 11'd6, pat}) begin
      miscompares++; $display("FAIL mid_ts_restart: got v=%b %h expected v=1 %h", out_valid, out_data, {2'd3, 3'b100, 11'd6, pat});
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_round_robin();
    test_backpressure();
    test_same_edge();
    test_registers();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
